// File: rtl/ifid_pipe_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifid_pipe_reg_pkg
// Description : Shared CPU constants used by the IF/ID pipeline register:
//               datapath widths, the NOP and HALT encodings, and the 1-bit
//               squash-FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package ifid_pipe_reg_pkg;

    // Datapath widths
    localparam int c_instr_w = 16;
    localparam int c_pc_w    = 16;

    // Instruction encodings
    localparam logic [c_instr_w-1:0] c_nop_instr  = 16'h0800;
    localparam logic [c_instr_w-1:0] c_halt_instr = 16'h0000;

    // Squash FSM states (explicit 1-bit encoding)
    localparam logic [0:0] c_idle   = 1'b0;
    localparam logic [0:0] c_squash = 1'b1;

endpackage : ifid_pipe_reg_pkg
`default_nettype wire

// File: rtl/ifid_pipe_reg_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : W-bit unsigned event counter that increments on inc and
//               sticks at all-ones instead of wrapping.
// Ports       : clk   - clock
//               rst_n - asynchronous active-low reset (clears count)
//               inc   - count this cycle
//               count - current count value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;
    logic         w_full;

    // All-ones means saturated: further increments are ignored.
    assign w_full = &r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && !w_full) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/ifid_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : ifid_pipe_reg
// Description : IF/ID pipeline register. Captures the fetched instruction,
//               PC+2 and HALT flag; holds on stall, loads a NOP bubble on
//               flush or when fetch is not done. A 1-bit FSM remembers a
//               flushed-but-outstanding imem fetch so its stale word is
//               dropped when it returns. Saturating stall/flush counters.
// Ports       : clk, rst_n            - clock, async active-low reset
//               Flush_IFID            - load bubble at next edge
//               Stall_disable_IFID    - hold all state (beats flush)
//               Instruction_in        - imem read data
//               InstrValid_in         - imem done, Instruction_in valid
//               ImemBusy_in           - imem access outstanding
//               PCplus2_in            - PC+2 of fetched word
//               CreateDump_in         - fetched word is HALT
//               Instruction_out       - registered instruction
//               PCplus2_out           - registered PC+2
//               Valid_out             - Instruction_out is a real instruction
//               CreateDump_out        - sticky halt flag
//               SquashPending_out     - FSM is in SQUASH
//               StallCount_out        - stalled cycles (saturating)
//               FlushCount_out        - effective flushes (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module ifid_pipe_reg
    import ifid_pipe_reg_pkg::*;
#(
    parameter int                   INSTR_W   = c_instr_w,
    parameter int                   PC_W      = c_pc_w,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = c_nop_instr,
    parameter int                   CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Flush_IFID,
    input  logic               Stall_disable_IFID,
    input  logic [INSTR_W-1:0] Instruction_in,
    input  logic               InstrValid_in,
    input  logic               ImemBusy_in,
    input  logic [PC_W-1:0]    PCplus2_in,
    input  logic               CreateDump_in,
    output logic [INSTR_W-1:0] Instruction_out,
    output logic [PC_W-1:0]    PCplus2_out,
    output logic               Valid_out,
    output logic               CreateDump_out,
    output logic               SquashPending_out,
    output logic [CNT_W-1:0]   StallCount_out,
    output logic [CNT_W-1:0]   FlushCount_out
);

    logic [INSTR_W-1:0] r_instr, w_instr_nxt;
    logic [PC_W-1:0]    r_pc,    w_pc_nxt;
    logic               r_valid, w_valid_nxt;
    logic               r_dump,  w_dump_nxt;
    logic [0:0]         r_state, w_state_nxt;
    logic               w_flush_eff;

    // A flush only counts when it is not overridden by a stall.
    assign w_flush_eff = Flush_IFID && !Stall_disable_IFID;

    // Next-state / next-data logic. Defaults hold everything, which is
    // exactly the stall behaviour.
    always_comb begin
        w_instr_nxt = r_instr;
        w_pc_nxt    = r_pc;
        w_valid_nxt = r_valid;
        w_dump_nxt  = r_dump;
        w_state_nxt = r_state;

        if (Stall_disable_IFID) begin
            // hold
        end else if (Flush_IFID) begin
            w_instr_nxt = NOP_INSTR;
            w_pc_nxt    = '0;
            w_valid_nxt = 1'b0;
            w_dump_nxt  = 1'b0;   // cancels a wrong-path HALT
            // Fetch still in flight: its word belongs to the flushed path.
            // Already in SQUASH stays in SQUASH (only one word is pending).
            if (ImemBusy_in && !InstrValid_in) begin
                w_state_nxt = c_squash;
            end
        end else if (r_state == c_idle) begin
            if (InstrValid_in) begin
                w_instr_nxt = Instruction_in;
                w_pc_nxt    = PCplus2_in;
                w_valid_nxt = 1'b1;
                w_dump_nxt  = r_dump | CreateDump_in;
            end else begin
                w_instr_nxt = NOP_INSTR;
                w_valid_nxt = 1'b0;
            end
        end else begin
            // SQUASH: bubble until the stale word returns, then drop it.
            w_instr_nxt = NOP_INSTR;
            w_valid_nxt = 1'b0;
            if (InstrValid_in) begin
                w_state_nxt = c_idle;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= NOP_INSTR;
            r_pc    <= '0;
            r_valid <= 1'b0;
            r_dump  <= 1'b0;
            r_state <= c_idle;
        end else begin
            r_instr <= w_instr_nxt;
            r_pc    <= w_pc_nxt;
            r_valid <= w_valid_nxt;
            r_dump  <= w_dump_nxt;
            r_state <= w_state_nxt;
        end
    end

    sat_counter #(
        .W     (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (Stall_disable_IFID),
        .count (StallCount_out)
    );

    sat_counter #(
        .W     (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_flush_eff),
        .count (FlushCount_out)
    );

    assign Instruction_out   = r_instr;
    assign PCplus2_out       = r_pc;
    assign Valid_out         = r_valid;
    assign CreateDump_out    = r_dump;
    assign SquashPending_out = (r_state == c_squash);

endmodule : ifid_pipe_reg
`default_nettype wire
